// File: rtl/rvx_core_hpm_counter_file.sv
// Machine-mode HPM CSR bank: event counters, per-counter selectors with sticky
// overflow flags, mcountinhibit, and a registered level overflow interrupt.
module rvx_core_hpm_counter_file #(
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clock_enable,
  input  logic [NUM_EVENTS-1:0] event_s1,
  input  logic [11:0]           csr_address_s2,
  input  logic [2:0]            csr_operation_s2,
  input  logic                  csr_write_request_s2,
  input  logic [4:0]            immediate_4_0_s2,
  input  logic [31:0]           rs1_data_s2,
  output logic [31:0]           csr_data_out_s2,
  output logic                  csr_hit_s2,
  output logic                  irq_overflow
);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [COUNTER_WIDTH-1:0] counter_r      [NUM_COUNTERS];
  logic [7:0]               sel_r          [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  ovfie_r;
  logic [NUM_COUNTERS-1:0]  of_r;
  logic [NUM_COUNTERS-1:0]  inhibit_r;
  logic                     irq_r;

  logic [31:0]              operand_s;
  logic [31:0]              wdata_s;
  logic [31:0]              rdata_s;
  logic [31:0]              inhibit_word_s;
  logic                     hit_s;
  logic                     write_en_s;
  logic                     match_inh_s;
  logic [NUM_COUNTERS-1:0]  match_evt_s;
  logic [NUM_COUNTERS-1:0]  match_lo_s;
  logic [NUM_COUNTERS-1:0]  match_hi_s;
  logic [NUM_COUNTERS-1:0]  ev_hit_s;
  logic [NUM_COUNTERS-1:0]  inc_s;
  logic [NUM_COUNTERS-1:0]  wrap_s;
  logic [NUM_COUNTERS-1:0]  of_next_s;
  logic [63:0]              next_wide_s    [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] counter_next_s [NUM_COUNTERS];

  // Place each inhibit bit at its hpm index; CY/IR/TM positions stay zero.
  always_comb begin
    inhibit_word_s = 32'd0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      inhibit_word_s[3+k] = inhibit_r[k];
    end
  end

  // Address decode and read mux; shadows alias the counter halves read-only.
  always_comb begin
    match_inh_s = (csr_address_s2 == 12'h320);
    hit_s       = match_inh_s;
    rdata_s     = {32{match_inh_s}} & inhibit_word_s;
    match_evt_s = {NUM_COUNTERS{1'b0}};
    match_lo_s  = {NUM_COUNTERS{1'b0}};
    match_hi_s  = {NUM_COUNTERS{1'b0}};
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      match_evt_s[k] = (csr_address_s2 == 12'h323 + 12'(k));
      match_lo_s[k]  = (csr_address_s2 == 12'hB03 + 12'(k));
      match_hi_s[k]  = (csr_address_s2 == 12'hB83 + 12'(k));
      hit_s = hit_s | match_evt_s[k] | match_lo_s[k] | match_hi_s[k]
            | (csr_address_s2 == 12'hC03 + 12'(k))
            | (csr_address_s2 == 12'hC83 + 12'(k));
      rdata_s = rdata_s
        | ({32{match_evt_s[k]}} & {of_r[k], ovfie_r[k], 22'd0, sel_r[k]})
        | ({32{match_lo_s[k] | (csr_address_s2 == 12'hC03 + 12'(k))}}
           & counter_r[k][31:0])
        | ({32{match_hi_s[k] | (csr_address_s2 == 12'hC83 + 12'(k))}}
           & 32'(64'(counter_r[k]) >> 32));
    end
  end

  // Read-modify-write data, using the pre-edge register value as old.
  always_comb begin
    operand_s = csr_operation_s2[2] ? {27'd0, immediate_4_0_s2} : rs1_data_s2;
    case (csr_operation_s2[1:0])
      OP_RW:   wdata_s = operand_s;
      OP_RS:   wdata_s = rdata_s | operand_s;
      OP_RC:   wdata_s = rdata_s & ~operand_s;
      default: wdata_s = rdata_s;
    endcase
  end

  assign write_en_s = clock_enable & csr_write_request_s2;

  // Per-counter next state; a write to either half suppresses that cycle's increment.
  always_comb begin
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      ev_hit_s[k] = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        ev_hit_s[k] = ev_hit_s[k] | ((sel_r[k] == 8'(e + 1)) & event_s1[e]);
      end
      inc_s[k]       = ~inhibit_r[k] & ev_hit_s[k];
      next_wide_s[k] = 64'(counter_r[k]);
      if (write_en_s & match_lo_s[k]) begin
        next_wide_s[k][31:0] = wdata_s;
      end else if (write_en_s & match_hi_s[k]) begin
        next_wide_s[k][63:32] = wdata_s;
      end else if (inc_s[k]) begin
        next_wide_s[k] = next_wide_s[k] + 64'd1;
      end else begin
        next_wide_s[k] = next_wide_s[k];
      end
      counter_next_s[k] = COUNTER_WIDTH'(next_wide_s[k]);
      wrap_s[k] = inc_s[k] & ~(write_en_s & (match_lo_s[k] | match_hi_s[k]))
                & (&counter_r[k]);
      of_next_s[k] = wrap_s[k] | ((write_en_s & match_evt_s[k]) ? wdata_s[31] : of_r[k]);
    end
  end

  // Counter, selector, flag and inhibit state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        counter_r[k] <= {COUNTER_WIDTH{1'b0}};
        sel_r[k]     <= 8'd0;
      end
      ovfie_r   <= {NUM_COUNTERS{1'b0}};
      of_r      <= {NUM_COUNTERS{1'b0}};
      inhibit_r <= {NUM_COUNTERS{1'b0}};
    end else if (clock_enable) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        counter_r[k] <= counter_next_s[k];
        of_r[k]      <= of_next_s[k];
        if (write_en_s & match_evt_s[k]) begin
          sel_r[k]   <= wdata_s[7:0];
          ovfie_r[k] <= wdata_s[30];
        end
        if (write_en_s & match_inh_s) begin
          inhibit_r[k] <= wdata_s[3+k];
        end
      end
    end
  end

  // Overflow interrupt lags the flags by one enabled edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else if (clock_enable) begin
      irq_r <= |(of_r & ovfie_r);
    end
  end

  assign csr_data_out_s2 = rdata_s;
  assign csr_hit_s2      = hit_s;
  assign irq_overflow    = irq_r;

endmodule

// File: tb/tb_rvx_core_hpm_counter_file.sv
// Directed bench for rvx_core_hpm_counter_file: a 64-bit and a 48-bit instance
// share one stimulus stream; each scenario task checks its own results.
module tb_rvx_core_hpm_counter_file;
  localparam int NC = 4;
  localparam int NE = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clock_enable;
  logic [NE-1:0] event_s1;
  logic [11:0]   csr_address_s2;
  logic [2:0]    csr_operation_s2;
  logic          csr_write_request_s2;
  logic [4:0]    immediate_4_0_s2;
  logic [31:0]   rs1_data_s2;
  logic [31:0]   data64, data48;
  logic          hit64, hit48, irq64, irq48;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rvx_core_hpm_counter_file #(.NUM_COUNTERS(NC), .NUM_EVENTS(NE), .COUNTER_WIDTH(64)) u_dut64 (
    .clock(clock), .reset_n(reset_n), .clock_enable(clock_enable), .event_s1(event_s1),
    .csr_address_s2(csr_address_s2), .csr_operation_s2(csr_operation_s2),
    .csr_write_request_s2(csr_write_request_s2), .immediate_4_0_s2(immediate_4_0_s2),
    .rs1_data_s2(rs1_data_s2), .csr_data_out_s2(data64), .csr_hit_s2(hit64),
    .irq_overflow(irq64));

  rvx_core_hpm_counter_file #(.NUM_COUNTERS(NC), .NUM_EVENTS(NE), .COUNTER_WIDTH(48)) u_dut48 (
    .clock(clock), .reset_n(reset_n), .clock_enable(clock_enable), .event_s1(event_s1),
    .csr_address_s2(csr_address_s2), .csr_operation_s2(csr_operation_s2),
    .csr_write_request_s2(csr_write_request_s2), .immediate_4_0_s2(immediate_4_0_s2),
    .rs1_data_s2(rs1_data_s2), .csr_data_out_s2(data48), .csr_hit_s2(hit48),
    .irq_overflow(irq48));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    csr_address_s2       = a;
    csr_operation_s2     = op;
    rs1_data_s2          = d;
    immediate_4_0_s2     = d[4:0];
    csr_write_request_s2 = 1'b1;
    step();
    csr_write_request_s2 = 1'b0;
  endtask

  task automatic look(input logic [11:0] a);
    csr_address_s2       = a;
    csr_write_request_s2 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] base [5];
    logic [11:0] unm  [4];
    base = '{12'h323, 12'hB03, 12'hB83, 12'hC03, 12'hC83};
    unm  = '{12'h321, 12'h322, 12'hB00, 12'h323 + 12'(NC)};
    reset_n = 1'b0; clock_enable = 1'b1; event_s1 = '0;
    csr_write_request_s2 = 1'b0; csr_operation_s2 = 3'b001;
    rs1_data_s2 = 32'd0; immediate_4_0_s2 = 5'd0; csr_address_s2 = 12'h320;
    step(); step();
    reset_n = 1'b1;
    total++; if (irq64 !== 1'b0) begin $display("FAIL reset_irq got=%b want=0", irq64); bad++; end
    look(12'h320);
    total++; if (data64 !== 32'd0 || hit64 !== 1'b1) begin
      $display("FAIL reset_inhibit data=%h hit=%b want 0/1", data64, hit64); bad++; end
    for (int k = 0; k < NC; k++) begin
      for (int j = 0; j < 5; j++) begin
        look(base[j] + 12'(k));
        total++; if (data64 !== 32'd0 || hit64 !== 1'b1) begin
          $display("FAIL reset_map addr=%h data=%h hit=%b want 0/1", csr_address_s2, data64, hit64);
          bad++; end
      end
    end
    for (int j = 0; j < 4; j++) begin
      look(unm[j]);
      total++; if (hit64 !== 1'b0 || data64 !== 32'd0) begin
        $display("FAIL unmapped addr=%h hit=%b data=%h want 0/0", unm[j], hit64, data64); bad++; end
    end
  endtask

  task automatic test_count_enable_inhibit();
    csr_write(12'h323, 3'b001, 32'd2);
    for (int i = 0; i < 10; i++) begin
      clock_enable = (i % 2 == 0) ? 1'b1 : 1'b0;
      event_s1 = 8'h02;
      step();
    end
    event_s1 = '0; clock_enable = 1'b1;
    look(12'hB03);
    total++; if (data64 !== 32'd5) begin $display("FAIL gated_count got=%0d want=5", data64); bad++; end
    csr_write(12'h320, 3'b001, 32'h8);
    event_s1 = 8'h02;
    for (int i = 0; i < 5; i++) step();
    event_s1 = '0;
    look(12'hB03);
    total++; if (data64 !== 32'd5) begin $display("FAIL inhibit_count got=%0d want=5", data64); bad++; end
    look(12'h320);
    total++; if (data64 !== 32'h8) begin $display("FAIL inhibit_read got=%h want=00000008", data64); bad++; end
    csr_write(12'h320, 3'b001, 32'h0);
  endtask

  task automatic test_overflow_irq();
    csr_write(12'hB03, 3'b001, 32'hFFFF_FFFF);
    csr_write(12'hB83, 3'b001, 32'hFFFF_FFFF);
    csr_write(12'h323, 3'b001, 32'h4000_0001);
    event_s1 = 8'h01;
    step();
    event_s1 = '0;
    look(12'hB03);
    total++; if (data64 !== 32'd0) begin $display("FAIL wrap_lo got=%h want=0", data64); bad++; end
    look(12'hB83);
    total++; if (data64 !== 32'd0) begin $display("FAIL wrap_hi got=%h want=0", data64); bad++; end
    look(12'h323);
    total++; if (data64 !== 32'hC000_0001) begin $display("FAIL wrap_of got=%h want=c0000001", data64); bad++; end
    total++; if (irq64 !== 1'b0) begin $display("FAIL irq_early got=%b want=0", irq64); bad++; end
    step();
    total++; if (irq64 !== 1'b1) begin $display("FAIL irq_set got=%b want=1", irq64); bad++; end
    csr_write(12'h323, 3'b011, 32'h8000_0000);
    total++; if (irq64 !== 1'b1) begin $display("FAIL irq_hold got=%b want=1", irq64); bad++; end
    step();
    total++; if (irq64 !== 1'b0) begin $display("FAIL irq_drop got=%b want=0", irq64); bad++; end
    look(12'h323);
    total++; if (data64 !== 32'h4000_0001) begin $display("FAIL of_clear got=%h want=40000001", data64); bad++; end
  endtask

  task automatic test_write_priority();
    event_s1 = 8'h01;
    csr_write(12'hB03, 3'b001, 32'h100);
    event_s1 = '0;
    look(12'hB03);
    total++; if (data64 !== 32'h100) begin $display("FAIL write_vs_inc got=%h want=00000100", data64); bad++; end
    csr_write(12'hB04, 3'b001, 32'h10);
    csr_write(12'hB04, 3'b110, 32'h1);
    look(12'hB04);
    total++; if (data64 !== 32'h11) begin $display("FAIL csrrsi got=%h want=00000011", data64); bad++; end
    csr_write(12'hC04, 3'b001, 32'hDEAD);
    look(12'hC04);
    total++; if (data64 !== 32'h11 || hit64 !== 1'b1) begin
      $display("FAIL shadow_ro data=%h hit=%b want 00000011/1", data64, hit64); bad++; end
  endtask

  task automatic test_width_48();
    csr_write(12'hB83, 3'b001, 32'hFFFF_FFFF);
    look(12'hB83);
    total++; if (data48 !== 32'h0000_FFFF) begin $display("FAIL hi48 got=%h want=0000ffff", data48); bad++; end
    total++; if (data64 !== 32'hFFFF_FFFF) begin $display("FAIL hi64 got=%h want=ffffffff", data64); bad++; end
    csr_write(12'hB03, 3'b001, 32'hFFFF_FFFF);
    csr_write(12'h323, 3'b001, 32'h1);
    event_s1 = 8'h01;
    step();
    event_s1 = '0;
    look(12'hB03);
    total++; if (data48 !== 32'd0) begin $display("FAIL wrap48_lo got=%h want=0", data48); bad++; end
    look(12'hB83);
    total++; if (data48 !== 32'd0) begin $display("FAIL wrap48_hi got=%h want=0", data48); bad++; end
    look(12'h323);
    total++; if (data48 !== 32'h8000_0001) begin $display("FAIL wrap48_of got=%h want=80000001", data48); bad++; end
    csr_write(12'h323, 3'b001, 32'(NE + 1));
    event_s1 = 8'hFF;
    for (int i = 0; i < 3; i++) step();
    event_s1 = '0;
    look(12'hB03);
    total++; if (data48 !== 32'd0) begin $display("FAIL sel_oob got=%h want=0", data48); bad++; end
  endtask

  task automatic test_of_race_and_async_reset();
    csr_write(12'hB03, 3'b001, 32'hFFFF_FFFF);
    csr_write(12'hB83, 3'b001, 32'hFFFF_FFFF);
    csr_write(12'h323, 3'b001, 32'h4000_0001);
    event_s1 = 8'h01;
    csr_write(12'h323, 3'b011, 32'h8000_0000);
    look(12'h323);
    total++; if (data64 !== 32'hC000_0001) begin $display("FAIL of_race got=%h want=c0000001", data64); bad++; end
    look(12'hB03);
    total++; if (data64 !== 32'd0) begin $display("FAIL race_wrap got=%h want=0", data64); bad++; end
    for (int i = 0; i < 3; i++) step();
    look(12'hB03);
    total++; if (data64 !== 32'd3) begin $display("FAIL midcount got=%0d want=3", data64); bad++; end
    total++; if (irq64 !== 1'b1) begin $display("FAIL pre_reset_irq got=%b want=1", irq64); bad++; end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (irq64 !== 1'b0 || data64 !== 32'd0) begin
      $display("FAIL async_reset irq=%b cnt=%h want 0/0", irq64, data64); bad++; end
    look(12'h323);
    total++; if (data64 !== 32'd0) begin $display("FAIL async_reset_evt got=%h want=0", data64); bad++; end
    event_s1 = '0;
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_count_enable_inhibit();
    test_overflow_irq();
    test_write_priority();
    test_width_48();
    test_of_race_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
